// File: rtl/npu_img_buf_ctrl_pkg.sv
// Shared types and constants for the NPU image ping-pong buffer controller.
package npu_pkg;

    localparam int ROWS_PER_IMG   = 28;
    localparam int NPU_MEM_ADDR_W = 12;
    localparam int NPU_MEM_DATA_W = 8;

    // Ownership of one image bank.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FILL  = 2'd1,
        FULL  = 2'd2,
        BUSY  = 2'd3
    } bank_state_t;

    // NPU sequencing state.
    typedef enum logic {
        H_IDLE = 1'b0,
        H_RUN  = 1'b1
    } hw_state_t;

    // The CPU may only write into the bank it is currently filling.
    function automatic logic cpu_may_write(input bank_state_t s);
        return (s == FILL);
    endfunction

    // The CPU may read back a bank it is filling or one that is waiting for the NPU.
    function automatic logic cpu_may_read(input bank_state_t s);
        return (s == FILL) || (s == FULL);
    endfunction

endpackage

// File: rtl/npu_bank_port_mux.sv
// Single-port arbiter for one image bank: grants the CPU or the NPU according
// to the bank's ownership state and remembers who issued a read last cycle.
module npu_bank_port_mux
    import npu_pkg::*;
#(
    parameter int ADDR_W = NPU_MEM_ADDR_W,
    parameter int DATA_W = NPU_MEM_DATA_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush_i,
    input  bank_state_t       state_i,
    input  logic              cpu_sel_i,
    input  logic              cpu_wr_i,
    input  logic              cpu_rd_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wrdata_i,
    input  logic              hw_sel_i,
    input  logic              hw_run_i,
    input  logic              hw_wr_i,
    input  logic              hw_rd_i,
    input  logic [ADDR_W-1:0] hw_addr_i,
    input  logic [DATA_W-1:0] hw_wrdata_i,
    output logic [ADDR_W-1:0] bank_addr_o,
    output logic              bank_wr_o,
    output logic [DATA_W-1:0] bank_wrdata_o,
    output logic              cpu_blocked_o,
    output logic              hw_blocked_o,
    output logic              cpu_rd_vld_o,
    output logic              hw_rd_vld_o
);

    logic cpu_wr_ok, cpu_rd_ok, hw_owns, hw_wr_ok, hw_rd_ok;
    logic cpu_rd_vld_q, hw_rd_vld_q;

    // Ownership is exclusive per bank, so at most one requester is ever granted.
    assign hw_owns   = hw_run_i && (state_i == BUSY);
    assign cpu_wr_ok = cpu_sel_i && cpu_wr_i && cpu_may_write(state_i) && !flush_i;
    assign cpu_rd_ok = cpu_sel_i && cpu_rd_i && cpu_may_read(state_i) && !flush_i;
    assign hw_wr_ok  = hw_sel_i && hw_wr_i && hw_owns && !flush_i;
    assign hw_rd_ok  = hw_sel_i && hw_rd_i && hw_owns && !flush_i;

    assign cpu_blocked_o = cpu_sel_i && ((cpu_wr_i && !cpu_may_write(state_i)) ||
                                         (cpu_rd_i && !cpu_may_read(state_i)));
    assign hw_blocked_o  = hw_sel_i && (hw_wr_i || hw_rd_i) && !hw_owns;

    // Steer the granted requester onto the bank port; idle port is all zero.
    always_comb begin
        bank_addr_o   = '0;
        bank_wr_o     = 1'b0;
        bank_wrdata_o = '0;
        if (hw_wr_ok || hw_rd_ok) begin
            bank_addr_o   = hw_addr_i;
            bank_wr_o     = hw_wr_ok;
            bank_wrdata_o = hw_wrdata_i;
        end else if (cpu_wr_ok || cpu_rd_ok) begin
            bank_addr_o   = cpu_addr_i;
            bank_wr_o     = cpu_wr_ok;
            bank_wrdata_o = cpu_wrdata_i;
        end
    end

    // Register which requester owns next cycle's synchronous read data.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cpu_rd_vld_q <= 1'b0;
            hw_rd_vld_q  <= 1'b0;
        end else if (flush_i) begin
            cpu_rd_vld_q <= 1'b0;
            hw_rd_vld_q  <= 1'b0;
        end else begin
            cpu_rd_vld_q <= cpu_rd_ok;
            hw_rd_vld_q  <= hw_rd_ok;
        end
    end

    assign cpu_rd_vld_o = cpu_rd_vld_q;
    assign hw_rd_vld_o  = hw_rd_vld_q;

endmodule

// File: rtl/npu_img_buf_ctrl.sv
// Ping-pong image buffer controller: CPU fills one bank row by row while the
// NPU processes the other; hands full images to the NPU and arbitrates ports.
module npu_img_buf_ctrl
    import npu_pkg::*;
#(
    parameter int ADDR_W       = npu_pkg::NPU_MEM_ADDR_W,
    parameter int DATA_W       = npu_pkg::NPU_MEM_DATA_W,
    parameter int ROWS_PER_IMG = npu_pkg::ROWS_PER_IMG,
    parameter int ROW_CNT_W    = 5
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 buf_flush_i,
    input  logic                 cpu_bank_i,
    input  logic [ADDR_W-1:0]    cpu_addr_i,
    input  logic                 cpu_wr_i,
    input  logic                 cpu_rd_i,
    input  logic [DATA_W-1:0]    cpu_wrdata_i,
    output logic [DATA_W-1:0]    cpu_rddata_o,
    input  logic                 write_row_i,
    input  logic [ADDR_W-1:0]    hw_addr_i,
    input  logic                 hw_wr_i,
    input  logic                 hw_rd_i,
    input  logic [DATA_W-1:0]    hw_wrdata_i,
    output logic [DATA_W-1:0]    hw_rddata_o,
    output logic                 npu_start_o,
    input  logic                 npu_done_i,
    input  logic                 npu_halt_i,
    output logic [ADDR_W-1:0]    bank0_addr_o,
    output logic                 bank0_wr_o,
    output logic [DATA_W-1:0]    bank0_wrdata_o,
    input  logic [DATA_W-1:0]    bank0_rddata_i,
    output logic [ADDR_W-1:0]    bank1_addr_o,
    output logic                 bank1_wr_o,
    output logic [DATA_W-1:0]    bank1_wrdata_o,
    input  logic [DATA_W-1:0]    bank1_rddata_i,
    output logic [ROW_CNT_W-1:0] img_num_rows_written_o,
    output logic                 fill_bank_o,
    output logic                 hw_bank_o,
    output logic                 cpu_buf_avail_o,
    input  logic                 err_clr_i,
    output logic                 err_invalid_cpu_rd_wr_o,
    output logic                 err_invalid_hw_rd_wr_o
);

    bank_state_t          bank_q [2];
    bank_state_t          bank_d [2];
    logic                 fill_ptr_q, fill_ptr_d;
    logic                 hw_ptr_q, hw_ptr_d;
    logic [ROW_CNT_W-1:0] rows_q, rows_d;
    hw_state_t            hw_state_q, hw_state_d;
    logic                 npu_start_q, npu_start_d;
    logic                 err_cpu_q, err_cpu_d;
    logic                 err_hw_q, err_hw_d;
    logic                 row_err;

    logic [ADDR_W-1:0]    port_addr   [2];
    logic                 port_wr     [2];
    logic [DATA_W-1:0]    port_wrdata [2];
    logic                 cpu_blocked [2];
    logic                 hw_blocked  [2];
    logic                 cpu_rd_vld  [2];
    logic                 hw_rd_vld   [2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            npu_bank_port_mux #(
                .ADDR_W (ADDR_W),
                .DATA_W (DATA_W)
            ) u_mux (
                .clk           (clk),
                .resetn        (resetn),
                .flush_i       (buf_flush_i),
                .state_i       (bank_q[gi]),
                .cpu_sel_i     (cpu_bank_i == 1'(gi)),
                .cpu_wr_i      (cpu_wr_i),
                .cpu_rd_i      (cpu_rd_i),
                .cpu_addr_i    (cpu_addr_i),
                .cpu_wrdata_i  (cpu_wrdata_i),
                .hw_sel_i      (hw_ptr_q == 1'(gi)),
                .hw_run_i      (hw_state_q == H_RUN),
                .hw_wr_i       (hw_wr_i),
                .hw_rd_i       (hw_rd_i),
                .hw_addr_i     (hw_addr_i),
                .hw_wrdata_i   (hw_wrdata_i),
                .bank_addr_o   (port_addr[gi]),
                .bank_wr_o     (port_wr[gi]),
                .bank_wrdata_o (port_wrdata[gi]),
                .cpu_blocked_o (cpu_blocked[gi]),
                .hw_blocked_o  (hw_blocked[gi]),
                .cpu_rd_vld_o  (cpu_rd_vld[gi]),
                .hw_rd_vld_o   (hw_rd_vld[gi])
            );
        end
    endgenerate

    assign bank0_addr_o   = port_addr[0];
    assign bank0_wr_o     = port_wr[0];
    assign bank0_wrdata_o = port_wrdata[0];
    assign bank1_addr_o   = port_addr[1];
    assign bank1_wr_o     = port_wr[1];
    assign bank1_wrdata_o = port_wrdata[1];

    // A requester reads only one bank per cycle, so OR-ing the gated data is a mux.
    assign cpu_rddata_o = ({DATA_W{cpu_rd_vld[0]}} & bank0_rddata_i) |
                          ({DATA_W{cpu_rd_vld[1]}} & bank1_rddata_i);
    assign hw_rddata_o  = ({DATA_W{hw_rd_vld[0]}} & bank0_rddata_i) |
                          ({DATA_W{hw_rd_vld[1]}} & bank1_rddata_i);

    assign img_num_rows_written_o  = rows_q;
    assign fill_bank_o             = fill_ptr_q;
    assign hw_bank_o               = hw_ptr_q;
    assign cpu_buf_avail_o         = (bank_q[0] == FILL) || (bank_q[1] == FILL);
    assign npu_start_o             = npu_start_q;
    assign err_invalid_cpu_rd_wr_o = err_cpu_q;
    assign err_invalid_hw_rd_wr_o  = err_hw_q;

    // Next state: row update first, then NPU done, then start scheduling.
    always_comb begin
        bank_d      = bank_q;
        fill_ptr_d  = fill_ptr_q;
        hw_ptr_d    = hw_ptr_q;
        rows_d      = rows_q;
        hw_state_d  = hw_state_q;
        npu_start_d = 1'b0;
        row_err     = 1'b0;

        if (write_row_i) begin
            if (bank_q[fill_ptr_q] != FILL) begin
                row_err = 1'b1;
            end else if (rows_q == ROW_CNT_W'(ROWS_PER_IMG - 1)) begin
                bank_d[fill_ptr_q] = FULL;
                rows_d             = '0;
                if (bank_q[~fill_ptr_q] == EMPTY) begin
                    bank_d[~fill_ptr_q] = FILL;
                    fill_ptr_d          = ~fill_ptr_q;
                end
            end else begin
                rows_d = rows_q + 1'b1;
            end
        end

        if ((hw_state_q == H_RUN) && npu_done_i) begin
            bank_d[hw_ptr_q] = EMPTY;
            hw_ptr_d         = ~hw_ptr_q;
            hw_state_d       = H_IDLE;
            // Give the freed bank straight back to the CPU if it has nothing to fill.
            if ((bank_d[0] != FILL) && (bank_d[1] != FILL)) begin
                bank_d[hw_ptr_q] = FILL;
                fill_ptr_d       = hw_ptr_q;
            end
        end else if ((hw_state_q == H_IDLE) && (bank_q[hw_ptr_q] == FULL) && !npu_halt_i) begin
            bank_d[hw_ptr_q] = BUSY;
            hw_state_d       = H_RUN;
            npu_start_d      = 1'b1;
        end

        // Sticky errors: a new violation wins over a clear in the same cycle.
        err_cpu_d = row_err || cpu_blocked[0] || cpu_blocked[1] || (err_cpu_q && !err_clr_i);
        err_hw_d  = hw_blocked[0] || hw_blocked[1] || (err_hw_q && !err_clr_i);

        if (buf_flush_i) begin
            bank_d[0]   = FILL;
            bank_d[1]   = EMPTY;
            fill_ptr_d  = 1'b0;
            hw_ptr_d    = 1'b0;
            rows_d      = '0;
            hw_state_d  = H_IDLE;
            npu_start_d = 1'b0;
            err_cpu_d   = 1'b0;
            err_hw_d    = 1'b0;
        end
    end

    // Controller state registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bank_q[0]   <= FILL;
            bank_q[1]   <= EMPTY;
            fill_ptr_q  <= 1'b0;
            hw_ptr_q    <= 1'b0;
            rows_q      <= '0;
            hw_state_q  <= H_IDLE;
            npu_start_q <= 1'b0;
            err_cpu_q   <= 1'b0;
            err_hw_q    <= 1'b0;
        end else begin
            bank_q      <= bank_d;
            fill_ptr_q  <= fill_ptr_d;
            hw_ptr_q    <= hw_ptr_d;
            rows_q      <= rows_d;
            hw_state_q  <= hw_state_d;
            npu_start_q <= npu_start_d;
            err_cpu_q   <= err_cpu_d;
            err_hw_q    <= err_hw_d;
        end
    end

endmodule

// File: tb/tb_npu_img_buf_ctrl.sv
// Bench for the NPU image ping-pong controller: directed scenarios followed by
// random traffic, all checked against a behavioural buffer model.
module tb_npu_img_buf_ctrl;

    localparam int AW   = 12;
    localparam int DW   = 8;
    localparam int ROWS = 28;
    localparam int S_EMPTY = 0;
    localparam int S_FILL  = 1;
    localparam int S_FULL  = 2;
    localparam int S_BUSY  = 3;

    logic          clk = 1'b0;
    logic          resetn;
    logic          buf_flush_i, cpu_bank_i, cpu_wr_i, cpu_rd_i, write_row_i;
    logic [AW-1:0] cpu_addr_i, hw_addr_i;
    logic [DW-1:0] cpu_wrdata_i, hw_wrdata_i, cpu_rddata_o, hw_rddata_o;
    logic          hw_wr_i, hw_rd_i, npu_start_o, npu_done_i, npu_halt_i;
    logic [AW-1:0] bank0_addr_o, bank1_addr_o;
    logic          bank0_wr_o, bank1_wr_o;
    logic [DW-1:0] bank0_wrdata_o, bank1_wrdata_o, bank0_rddata_i, bank1_rddata_i;
    logic [4:0]    img_num_rows_written_o;
    logic          fill_bank_o, hw_bank_o, cpu_buf_avail_o, err_clr_i;
    logic          err_invalid_cpu_rd_wr_o, err_invalid_hw_rd_wr_o;
    logic          mem_clr;

    int n_vec = 0;
    int n_mis = 0;

    // Behavioural model of the buffer system
    int            m_st [2];
    int            m_fill, m_hw, m_rows;
    bit            m_run, m_start, m_ecpu, m_ehw;
    logic [DW-1:0] ref_mem [2][4096];
    logic [DW-1:0] exp_cpu_rd, exp_hw_rd;

    always #5 clk = ~clk;

    npu_img_buf_ctrl dut (
        .clk(clk), .resetn(resetn), .buf_flush_i(buf_flush_i),
        .cpu_bank_i(cpu_bank_i), .cpu_addr_i(cpu_addr_i), .cpu_wr_i(cpu_wr_i),
        .cpu_rd_i(cpu_rd_i), .cpu_wrdata_i(cpu_wrdata_i), .cpu_rddata_o(cpu_rddata_o),
        .write_row_i(write_row_i), .hw_addr_i(hw_addr_i), .hw_wr_i(hw_wr_i),
        .hw_rd_i(hw_rd_i), .hw_wrdata_i(hw_wrdata_i), .hw_rddata_o(hw_rddata_o),
        .npu_start_o(npu_start_o), .npu_done_i(npu_done_i), .npu_halt_i(npu_halt_i),
        .bank0_addr_o(bank0_addr_o), .bank0_wr_o(bank0_wr_o), .bank0_wrdata_o(bank0_wrdata_o),
        .bank0_rddata_i(bank0_rddata_i),
        .bank1_addr_o(bank1_addr_o), .bank1_wr_o(bank1_wr_o), .bank1_wrdata_o(bank1_wrdata_o),
        .bank1_rddata_i(bank1_rddata_i),
        .img_num_rows_written_o(img_num_rows_written_o), .fill_bank_o(fill_bank_o),
        .hw_bank_o(hw_bank_o), .cpu_buf_avail_o(cpu_buf_avail_o), .err_clr_i(err_clr_i),
        .err_invalid_cpu_rd_wr_o(err_invalid_cpu_rd_wr_o),
        .err_invalid_hw_rd_wr_o(err_invalid_hw_rd_wr_o)
    );

    // The two physical 4 KB banks with synchronous read
    logic [DW-1:0] mem0 [4096];
    logic [DW-1:0] mem1 [4096];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 4096; i++) mem0[i] <= '0;
        end else if (bank0_wr_o) begin
            mem0[bank0_addr_o] <= bank0_wrdata_o;
        end
        bank0_rddata_i <= mem0[bank0_addr_o];
    end

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 4096; i++) mem1[i] <= '0;
        end else if (bank1_wr_o) begin
            mem1[bank1_addr_o] <= bank1_wrdata_o;
        end
        bank1_rddata_i <= mem1[bank1_addr_o];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_st[0] = S_FILL;
        m_st[1] = S_EMPTY;
        m_fill = 0; m_hw = 0; m_rows = 0;
        m_run = 0; m_start = 0; m_ecpu = 0; m_ehw = 0;
        exp_cpu_rd = '0; exp_hw_rd = '0;
    endtask

    task automatic idle_inputs();
        buf_flush_i = 0; cpu_bank_i = 0; cpu_addr_i = '0; cpu_wr_i = 0; cpu_rd_i = 0;
        cpu_wrdata_i = '0; write_row_i = 0; hw_addr_i = '0; hw_wr_i = 0; hw_rd_i = 0;
        hw_wrdata_i = '0; npu_done_i = 0; npu_halt_i = 0; err_clr_i = 0;
    endtask

    // One clock: check bank strobes, advance the model, check registered outputs.
    task automatic cycle();
        bit            any_fill, c_wr_ok, c_rd_ok, h_ok, c_blk, h_blk, r_err, start_now;
        bit            e_wr0, e_wr1;
        int            cb, freed;
        logic [DW-1:0] nxt_c, nxt_h;
        #1;
        cb       = int'(cpu_bank_i);
        any_fill = (m_st[0] == S_FILL) || (m_st[1] == S_FILL);
        c_wr_ok  = cpu_wr_i && !buf_flush_i && (m_st[cb] == S_FILL);
        c_rd_ok  = cpu_rd_i && !buf_flush_i && (m_st[cb] == S_FILL || m_st[cb] == S_FULL);
        h_ok     = m_run && !buf_flush_i;
        c_blk    = (cpu_wr_i && m_st[cb] != S_FILL) ||
                   (cpu_rd_i && !(m_st[cb] == S_FILL || m_st[cb] == S_FULL));
        h_blk    = (hw_wr_i || hw_rd_i) && !m_run;
        r_err    = write_row_i && !any_fill;
        e_wr0    = (c_wr_ok && cb == 0) || (h_ok && hw_wr_i && m_hw == 0);
        e_wr1    = (c_wr_ok && cb == 1) || (h_ok && hw_wr_i && m_hw == 1);
        chk("bank0_wr", 32'(bank0_wr_o), 32'(e_wr0));
        chk("bank1_wr", 32'(bank1_wr_o), 32'(e_wr1));
        if (c_wr_ok) begin
            chk("cpu_wr_addr", 32'(cb == 0 ? bank0_addr_o : bank1_addr_o), 32'(cpu_addr_i));
            chk("cpu_wr_data", 32'(cb == 0 ? bank0_wrdata_o : bank1_wrdata_o), 32'(cpu_wrdata_i));
        end
        if (h_ok && hw_wr_i) begin
            chk("hw_wr_addr", 32'(m_hw == 0 ? bank0_addr_o : bank1_addr_o), 32'(hw_addr_i));
            chk("hw_wr_data", 32'(m_hw == 0 ? bank0_wrdata_o : bank1_wrdata_o), 32'(hw_wrdata_i));
        end
        nxt_c = c_rd_ok ? ref_mem[cb][cpu_addr_i] : '0;
        nxt_h = (h_ok && hw_rd_i) ? ref_mem[m_hw][hw_addr_i] : '0;
        if (c_wr_ok) ref_mem[cb][cpu_addr_i] = cpu_wrdata_i;
        if (h_ok && hw_wr_i) ref_mem[m_hw][hw_addr_i] = hw_wrdata_i;

        start_now = !m_run && (m_st[m_hw] == S_FULL) && !npu_halt_i;
        if (buf_flush_i) begin
            m_reset();
        end else begin
            if (write_row_i && any_fill) begin
                if (m_rows == ROWS - 1) begin
                    m_st[m_fill] = S_FULL;
                    m_rows = 0;
                    if (m_st[1 - m_fill] == S_EMPTY) begin
                        m_fill = 1 - m_fill;
                        m_st[m_fill] = S_FILL;
                    end
                end else begin
                    m_rows++;
                end
            end
            if (m_run && npu_done_i) begin
                freed = m_hw;
                m_st[freed] = S_EMPTY;
                m_hw = 1 - m_hw;
                m_run = 0;
                if (m_st[0] != S_FILL && m_st[1] != S_FILL) begin
                    m_st[freed] = S_FILL;
                    m_fill = freed;
                end
            end
            if (start_now) begin
                m_st[m_hw] = S_BUSY;
                m_run = 1;
            end
            m_start = start_now;
            m_ecpu = (r_err || c_blk) ? 1'b1 : (err_clr_i ? 1'b0 : m_ecpu);
            m_ehw  = h_blk ? 1'b1 : (err_clr_i ? 1'b0 : m_ehw);
            exp_cpu_rd = nxt_c;
            exp_hw_rd  = nxt_h;
        end

        @(posedge clk);
        #1;
        chk("npu_start", 32'(npu_start_o), 32'(m_start));
        chk("fill_bank", 32'(fill_bank_o), 32'(m_fill));
        chk("hw_bank", 32'(hw_bank_o), 32'(m_hw));
        chk("rows", 32'(img_num_rows_written_o), 32'(m_rows));
        chk("avail", 32'(cpu_buf_avail_o), 32'(m_st[0] == S_FILL || m_st[1] == S_FILL));
        chk("err_cpu", 32'(err_invalid_cpu_rd_wr_o), 32'(m_ecpu));
        chk("err_hw", 32'(err_invalid_hw_rd_wr_o), 32'(m_ehw));
        chk("cpu_rddata", 32'(cpu_rddata_o), 32'(exp_cpu_rd));
        chk("hw_rddata", 32'(hw_rddata_o), 32'(exp_hw_rd));
    endtask

    task automatic write_rows(input int n);
        write_row_i = 1;
        for (int i = 0; i < n; i++) cycle();
        write_row_i = 0;
    endtask

    initial begin
        int acc;
        idle_inputs();
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < 4096; a++) ref_mem[b][a] = '0;
        m_reset();
        resetn  = 0;
        mem_clr = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_fill_bank", 32'(fill_bank_o), 32'd0);
        chk("rst_hw_bank", 32'(hw_bank_o), 32'd0);
        chk("rst_rows", 32'(img_num_rows_written_o), 32'd0);
        chk("rst_avail", 32'(cpu_buf_avail_o), 32'd1);
        chk("rst_start", 32'(npu_start_o), 32'd0);
        chk("rst_err_cpu", 32'(err_invalid_cpu_rd_wr_o), 32'd0);
        chk("rst_err_hw", 32'(err_invalid_hw_rd_wr_o), 32'd0);
        chk("rst_bank_wr", 32'({bank1_wr_o, bank0_wr_o}), 32'd0);
        chk("rst_rddata", 32'({cpu_rddata_o, hw_rddata_o}), 32'd0);
        resetn  = 1;
        mem_clr = 0;

        // 1: fill bank0 with 0x00..0x1B, one row per cycle
        for (int i = 0; i < ROWS; i++) begin
            cpu_wr_i = 1; cpu_bank_i = 0; cpu_addr_i = AW'(i); cpu_wrdata_i = DW'(i);
            write_row_i = 1;
            cycle();
        end
        idle_inputs();
        chk("s1_fill_bank", 32'(fill_bank_o), 32'd1);
        chk("s1_rows", 32'(img_num_rows_written_o), 32'd0);
        chk("s1_no_start_yet", 32'(npu_start_o), 32'd0);
        cycle();
        chk("s1_start", 32'(npu_start_o), 32'd1);
        cycle();
        chk("s1_start_once", 32'(npu_start_o), 32'd0);
        hw_rd_i = 1; hw_addr_i = 12'h005;
        cycle();
        chk("s1_hw_rd", 32'(hw_rddata_o), 32'h05);
        hw_rd_i = 0; npu_done_i = 1;
        cycle();
        npu_done_i = 0;

        // 2: fill both banks without a done
        write_rows(ROWS);
        repeat (2) cycle();
        write_rows(ROWS);
        chk("s2_avail", 32'(cpu_buf_avail_o), 32'd0);
        write_rows(1);
        chk("s2_err_cpu", 32'(err_invalid_cpu_rd_wr_o), 32'd1);
        err_clr_i = 1;
        cycle();
        err_clr_i = 0;
        chk("s2_err_clr", 32'(err_invalid_cpu_rd_wr_o), 32'd0);

        // 3: last row into bank1 coincides with done on bank0
        npu_done_i = 1;
        cycle();
        npu_done_i = 0;
        repeat (2) cycle();
        write_rows(ROWS - 1);
        write_row_i = 1; npu_done_i = 1;
        cycle();
        idle_inputs();
        chk("s3_fill_bank", 32'(fill_bank_o), 32'd0);
        chk("s3_hw_bank", 32'(hw_bank_o), 32'd1);
        cycle();
        chk("s3_start", 32'(npu_start_o), 32'd1);

        // 4: CPU write to BUSY bank1, then NPU read while idle
        cpu_wr_i = 1; cpu_bank_i = 1; cpu_addr_i = 12'h003; cpu_wrdata_i = 8'hAA;
        cycle();
        idle_inputs();
        chk("s4_err_cpu", 32'(err_invalid_cpu_rd_wr_o), 32'd1);
        npu_done_i = 1;
        cycle();
        idle_inputs();
        hw_rd_i = 1; hw_addr_i = 12'h005;
        cycle();
        idle_inputs();
        chk("s4_err_hw", 32'(err_invalid_hw_rd_wr_o), 32'd1);
        chk("s4_hw_rd_zero", 32'(hw_rddata_o), 32'd0);
        err_clr_i = 1;
        cycle();
        err_clr_i = 0;

        // 5: halt holds back the start until released
        npu_halt_i = 1;
        write_rows(ROWS);
        repeat (3) begin
            cycle();
            chk("s5_halted", 32'(npu_start_o), 32'd0);
        end
        npu_halt_i = 0;
        cycle();
        chk("s5_start", 32'(npu_start_o), 32'd1);

        // 6: flush mid-run, later done is ignored
        write_rows(5);
        buf_flush_i = 1;
        cycle();
        buf_flush_i = 0; npu_done_i = 1;
        cycle();
        npu_done_i = 0;
        chk("s6_rows", 32'(img_num_rows_written_o), 32'd0);
        chk("s6_fill_bank", 32'(fill_bank_o), 32'd0);
        chk("s6_hw_bank", 32'(hw_bank_o), 32'd0);
        chk("s6_avail", 32'(cpu_buf_avail_o), 32'd1);

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            write_row_i = ($urandom_range(0, 2) == 0);
            npu_done_i  = ($urandom_range(0, 5) == 0);
            npu_halt_i  = ($urandom_range(0, 3) == 0);
            err_clr_i   = ($urandom_range(0, 15) == 0);
            buf_flush_i = ($urandom_range(0, 299) == 0);
            acc          = $urandom_range(0, 2);
            cpu_wr_i     = (acc == 1);
            cpu_rd_i     = (acc == 2);
            cpu_bank_i   = 1'($urandom_range(0, 1));
            cpu_addr_i   = AW'($urandom_range(0, 31));
            cpu_wrdata_i = DW'($urandom);
            acc          = $urandom_range(0, 2);
            hw_wr_i      = (acc == 1);
            hw_rd_i      = (acc == 2);
            hw_addr_i    = AW'($urandom_range(0, 31));
            hw_wrdata_i  = DW'($urandom);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/npu_img_buf_ctrl.md
Name: npu_img_buf_ctrl

Overview:
- Ping-pong controller for the two 4 KB x 8 image banks (mem0/mem1) that sit between the AHB CSR/memory decoder and the NPU datapath.
- Tracks the CPU's row writes into the fill bank and hands full images to the NPU.
- Sequences NPU start/done and arbitrates each bank's single port between CPU and hardware.
- Generates the row-count and invalid-access status that the CSR block reports.

Parameters:
ADDR_W, 12, bank address width
DATA_W, 8, bank data width
ROWS_PER_IMG, 28, write_row pulses per complete image
ROW_CNT_W, 5, width of row counter

Ports:
clk  in  1  clock
resetn  in  1  reset, asynchronous, active-low
buf_flush_i  in  1  synchronous soft reset of all buffer state
cpu_bank_i  in  1  bank targeted by CPU access (0=mem0, 1=mem1)
cpu_addr_i  in  ADDR_W  CPU bank address
cpu_wr_i  in  1  CPU write strobe
cpu_rd_i  in  1  CPU read strobe
cpu_wrdata_i  in  DATA_W  CPU write data
cpu_rddata_o  out  DATA_W  CPU read data, one cycle after cpu_rd_i
write_row_i  in  1  one-cycle pulse: CPU finished one image row
hw_addr_i  in  ADDR_W  NPU read/write address (bank implied by hw_bank_o)
hw_wr_i  in  1  NPU write strobe
hw_rd_i  in  1  NPU read strobe
hw_wrdata_i  in  DATA_W  NPU write data
hw_rddata_o  out  DATA_W  NPU read data, one cycle after hw_rd_i
npu_start_o  out  1  one-cycle start pulse to NPU
npu_done_i  in  1  one-cycle done pulse from NPU
npu_halt_i  in  1  inhibits issuing new starts
bankN_addr_o / bankN_wr_o / bankN_wrdata_o  out  ADDR_W/1/DATA_W  port to bank N (N=0,1)
bankN_rddata_i  in  DATA_W  bank N synchronous read data
img_num_rows_written_o  out  ROW_CNT_W  rows written into current fill bank
fill_bank_o  out  1  bank currently filled by CPU
hw_bank_o  out  1  bank owned/next owned by NPU
cpu_buf_avail_o  out  1  a bank is in FILL state
err_clr_i  in  1  clears sticky error flags
err_invalid_cpu_rd_wr_o  out  1  sticky: CPU access blocked
err_invalid_hw_rd_wr_o  out  1  sticky: NPU access blocked

Behaviour:
- Per-bank state: EMPTY, FILL, FULL, BUSY. Pointers fill_ptr and hw_ptr. NPU FSM: H_IDLE, H_RUN.
- Reset (async) and buf_flush_i (sync) produce the same state:
  - bank0=FILL, bank1=EMPTY, fill_ptr=0, hw_ptr=0, rows=0, FSM=H_IDLE.
  - Both error flags 0, npu_start_o=0, all bankN_wr_o=0, rddata outputs 0.
  - A flush while in H_RUN abandons the run; a later npu_done_i is ignored.
- Rows:
  - write_row_i with a FILL bank present: rows++.
  - On the pulse where rows==ROWS_PER_IMG-1: bank[fill_ptr]->FULL and rows->0.
  - If the other bank is EMPTY, it becomes FILL and fill_ptr toggles. Otherwise no FILL bank exists and cpu_buf_avail_o=0.
  - write_row_i with no FILL bank: ignored and err_invalid_cpu_rd_wr set.
- Scheduler:
  - In H_IDLE, bank[hw_ptr]==FULL and !npu_halt_i: bank->BUSY, FSM->H_RUN, npu_start_o=1 for exactly the next cycle.
  - Latency is one cycle from registered FULL to the start pulse.
  - npu_halt_i never aborts a run in progress.
- Done:
  - In H_RUN, npu_done_i: bank[hw_ptr]->EMPTY, hw_ptr toggles, FSM->H_IDLE.
  - If no FILL bank exists after this cycle's row update, the freed bank becomes FILL and fill_ptr points to it.
  - npu_done_i in H_IDLE is ignored.
- Simultaneous last write_row and npu_done_i: the row update is applied first, then the done update. Example: bank0 FILL completes while bank1 BUSY finishes, giving bank0=FULL, bank1=FILL, fill_ptr=1, hw_ptr=0, then a start on bank0.
- CPU arbitration (combinational):
  - Writes are allowed only to a FILL bank.
  - Reads are allowed to a FILL or FULL bank.
  - A blocked access drives no bank strobe, sets err_invalid_cpu_rd_wr, and read data returns 0.
- NPU arbitration:
  - Reads and writes are allowed only in H_RUN, to bank[hw_ptr].
  - Accesses outside H_RUN are blocked and set err_invalid_hw_rd_wr.
  - The CPU and NPU never target the same bank in one cycle, because states are exclusive.
- Read data:
  - The read-data mux select and a valid bit are registered with the strobe.
  - Data appears on cpu_rddata_o / hw_rddata_o one cycle after the strobe.
  - The output is 0 when the access was blocked.
- Error flags: sticky; set dominates err_clr_i in the same cycle.

Decomposition:
- Package npu_pkg:
  - bank_state_t (EMPTY/FILL/FULL/BUSY) and hw_state_t (H_IDLE/H_RUN).
  - Constants ROWS_PER_IMG, NPU_MEM_ADDR_W, NPU_MEM_DATA_W.
- Sub-module npu_bank_port_mux, instantiated twice:
  - Takes the bank state and both requesters.
  - Outputs the bank port, the grant/blocked indications and the registered read select.

Test Plan:
1. Reset, 28 write_row pulses with CPU writes 0x00..0x1B to bank0 -> bank0 FULL, fill_bank_o=1, rows=0, npu_start_o pulses exactly once; NPU reads of addr 0x005 return 0x05 one cycle later.
2. Fill bank0 and bank1 with no npu_done_i -> cpu_buf_avail_o=0; a 29th write_row sets err_invalid_cpu_rd_wr_o; err_clr_i clears it.
3. Last write_row to bank1 in the same cycle as npu_done_i for bank0 -> bank1 FULL, bank0 FILL, fill_bank_o=0, hw_bank_o=1, start pulse for bank1 the next cycle.
4. CPU write to the BUSY bank, and NPU read while H_IDLE -> no bankN_wr_o, both error flags set, rddata 0.
5. npu_halt_i=1 with bank0 FULL -> no start; deassert -> npu_start_o one cycle later.
6. buf_flush_i mid-run, then npu_done_i -> reset state restored, done ignored, rows=0.
